btb_update_ctrl: RTL and testbench

Update scheduler sitting between branch resolution/commit and the direct-mapped BTB write port. It accepts up to two branch updates per cycle from the two commit lanes, buffers them in a small in-order FIFO and drains one per cycle into the BTB's single update port. It also sequences a multi-cycle invalidate-all sweep over every BTB index on a flush request, such as a context switch or an icache invalidate. During a sweep, normal updates are held off.

---
 rtl/btb_update_ctrl_if.sv | 52 +++++
 rtl/btb_update_ctrl.sv | 144 ++++++++++++++
 tb/tb_btb_update_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Bundle between commit lanes, the BTB write/invalidate ports and the update scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline's view.
interface btb_update_ctrl_if #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_ENTRIES = 512,
  parameter int unsigned INDEX_BITS  = $clog2(NUM_ENTRIES)
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Commit lanes (lane 0 is older in program order)
  logic                  req0_valid;
  logic [31:0]           req0_pc;
  logic [31:0]           req0_target;
  logic [1:0]            req0_type;
  logic                  req1_valid;
  logic [31:0]           req1_pc;
  logic [31:0]           req1_target;
  logic [1:0]            req1_type;
  logic                  req_ready;

  // Invalidate-all control
  logic                  flush_req;
  logic                  flush_busy;

  // BTB write / invalidate ports
  logic                  btb_upd_valid;
  logic [31:0]           btb_upd_pc;
  logic [31:0]           btb_upd_target;
  logic [1:0]            btb_upd_type;
  logic                  btb_inv_valid;
  logic [INDEX_BITS-1:0] btb_inv_index;

  logic [CntW-1:0]       fifo_count;

  modport master (
    output req0_valid, req0_pc, req0_target, req0_type,
    output req1_valid, req1_pc, req1_target, req1_type,
    output flush_req,
    input  req_ready, flush_busy,
    input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_type,
    input  btb_inv_valid, btb_inv_index, fifo_count
  );

  modport slave (
    input  req0_valid, req0_pc, req0_target, req0_type,
    input  req1_valid, req1_pc, req1_target, req1_type,
    input  flush_req,
    output req_ready, flush_busy,
    output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_type,
    output btb_inv_valid, btb_inv_index, fifo_count
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update scheduler: buffers up to two committed branch updates per cycle in an in-order
// FIFO, drains one per cycle into the BTB write port, and runs an invalidate-all sweep over
// every BTB index on a flush request. Updates are held off while the sweep runs.
module btb_update_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_ENTRIES = 512,
  parameter int unsigned INDEX_BITS  = $clog2(NUM_ENTRIES)
) (
  input logic             clk,
  input logic             rst,
  btb_update_ctrl_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [INDEX_BITS-1:0] LastIdx = INDEX_BITS'(NUM_ENTRIES - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic [31:0] pc_mem_q  [FIFO_DEPTH];
  logic [31:0] pc_mem_d  [FIFO_DEPTH];
  logic [31:0] tgt_mem_q [FIFO_DEPTH];
  logic [31:0] tgt_mem_d [FIFO_DEPTH];
  logic [1:0]  typ_mem_q [FIFO_DEPTH];
  logic [1:0]  typ_mem_d [FIFO_DEPTH];

  logic            req_ready;
  logic            empty;
  logic            dup;
  logic            enq0, enq1, deq;
  logic [PtrW-1:0] wr_idx1;

  // Handshake decode: who is written and whether the head pops this cycle
  always_comb begin
    req_ready = (CntW'(FIFO_DEPTH) - count_q) >= CntW'(2);
    empty     = (count_q == '0);
    // Same word-aligned PC on both lanes: the younger lane carries the newer outcome
    dup       = bus.req0_valid && bus.req1_valid && (bus.req0_pc[31:2] == bus.req1_pc[31:2]);
    // A flush discards everything presented in its own cycle
    enq0      = bus.req0_valid && req_ready && !dup && !bus.flush_req;
    enq1      = bus.req1_valid && req_ready && !bus.flush_req;
    deq       = !empty && (state_q == StIdle) && !bus.flush_req;
    wr_idx1   = wr_ptr_q + PtrW'(enq0);
  end

  // FIFO next-state: lane 0 lands before lane 1 so program order is kept
  always_comb begin
    pc_mem_d  = pc_mem_q;
    tgt_mem_d = tgt_mem_q;
    typ_mem_d = typ_mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (bus.flush_req) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq0) begin
        pc_mem_d[wr_ptr_q]  = bus.req0_pc;
        tgt_mem_d[wr_ptr_q] = bus.req0_target;
        typ_mem_d[wr_ptr_q] = bus.req0_type;
      end
      if (enq1) begin
        pc_mem_d[wr_idx1]  = bus.req1_pc;
        tgt_mem_d[wr_idx1] = bus.req1_target;
        typ_mem_d[wr_idx1] = bus.req1_type;
      end
      wr_ptr_d = wr_ptr_q + PtrW'(enq0) + PtrW'(enq1);
      rd_ptr_d = rd_ptr_q + PtrW'(deq);
      count_d  = count_q + CntW'(enq0) + CntW'(enq1) - CntW'(deq);
    end
  end

  // Sweep FSM next-state; a flush during a sweep does not restart the index
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.flush_req) begin
          state_d     = StSweep;
          sweep_cnt_d = '0;
        end
      end
      StSweep: begin
        if (sweep_cnt_q == LastIdx) begin
          state_d     = StIdle;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + INDEX_BITS'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        sweep_cnt_d = '0;
      end
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_cnt_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the entry is not occupied
  always_ff @(posedge clk) begin
    pc_mem_q  <= pc_mem_d;
    tgt_mem_q <= tgt_mem_d;
    typ_mem_q <= typ_mem_d;
  end

  // Output drive: write data gated to zero when no write is issued
  always_comb begin
    bus.req_ready      = req_ready;
    bus.flush_busy     = (state_q == StSweep);
    bus.btb_upd_valid  = deq;
    bus.btb_upd_pc     = deq ? pc_mem_q[rd_ptr_q]  : '0;
    bus.btb_upd_target = deq ? tgt_mem_q[rd_ptr_q] : '0;
    bus.btb_upd_type   = deq ? typ_mem_q[rd_ptr_q] : '0;
    bus.btb_inv_valid  = (state_q == StSweep);
    bus.btb_inv_index  = (state_q == StSweep) ? sweep_cnt_q : '0;
    bus.fifo_count     = count_q;
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: single/dual/duplicate updates, back-to-back flow,
// backpressure held by a sweep, flush clearing, and reset in the middle of a sweep.
module tb_btb_update_ctrl;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  btb_update_ctrl_if #(.FIFO_DEPTH(4), .NUM_ENTRIES(512)) bus ();

  btb_update_ctrl #(.FIFO_DEPTH(4), .NUM_ENTRIES(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_pc     = '0;
    bus.req0_target = '0;
    bus.req0_type   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_pc     = '0;
    bus.req1_target = '0;
    bus.req1_type   = '0;
    bus.flush_req   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    vecs++; if (bus.req_ready !== 1'b1) begin errs++;
      $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    vecs++; if (bus.fifo_count !== 3'd0) begin errs++;
      $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    vecs++; if (bus.flush_busy !== 1'b0) begin errs++;
      $display("FAIL reset_busy got %b want 0", bus.flush_busy); end
    vecs++; if (bus.btb_upd_valid !== 1'b0 || bus.btb_inv_valid !== 1'b0) begin errs++;
      $display("FAIL reset_valids got %b/%b want 0/0", bus.btb_upd_valid, bus.btb_inv_valid); end
    vecs++; if (bus.btb_upd_pc !== 32'd0 || bus.btb_inv_index !== 9'd0) begin errs++;
      $display("FAIL reset_data got %h/%0d want 0/0", bus.btb_upd_pc, bus.btb_inv_index); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.req0_valid  = 1'b1;
    bus.req0_pc     = 32'h0040_0010;
    bus.req0_target = 32'h0040_0100;
    bus.req0_type   = 2'b00;
    step();
    idle_inputs();
    #1;
    vecs++; if (bus.btb_upd_valid !== 1'b1) begin errs++;
      $display("FAIL single_valid got %b want 1", bus.btb_upd_valid); end
    vecs++; if (bus.btb_upd_pc !== 32'h0040_0010 || bus.btb_upd_target !== 32'h0040_0100) begin
      errs++; $display("FAIL single_data got %h/%h want 00400010/00400100",
                       bus.btb_upd_pc, bus.btb_upd_target); end
    vecs++; if (bus.btb_upd_type !== 2'b00 || bus.fifo_count !== 3'd1) begin errs++;
      $display("FAIL single_type_cnt got %b/%0d want 00/1", bus.btb_upd_type, bus.fifo_count); end
    step();
    vecs++; if (bus.fifo_count !== 3'd0 || bus.btb_upd_valid !== 1'b0) begin errs++;
      $display("FAIL single_drain got %0d/%b want 0/0", bus.fifo_count, bus.btb_upd_valid); end
  endtask

  task automatic test_dual();
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h100; bus.req0_target = 32'h1100; bus.req0_type = 2'b01;
    bus.req1_valid = 1'b1; bus.req1_pc = 32'h200; bus.req1_target = 32'h2200; bus.req1_type = 2'b10;
    step();
    idle_inputs();
    #1;
    vecs++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_pc !== 32'h100 ||
                bus.btb_upd_target !== 32'h1100 || bus.btb_upd_type !== 2'b01) begin errs++;
      $display("FAIL dual_first got %b %h %h %b want 1 100 1100 01", bus.btb_upd_valid,
               bus.btb_upd_pc, bus.btb_upd_target, bus.btb_upd_type); end
    vecs++; if (bus.fifo_count !== 3'd2) begin errs++;
      $display("FAIL dual_count got %0d want 2", bus.fifo_count); end
    step();
    vecs++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_pc !== 32'h200 ||
                bus.btb_upd_target !== 32'h2200 || bus.btb_upd_type !== 2'b10) begin errs++;
      $display("FAIL dual_second got %b %h %h %b want 1 200 2200 10", bus.btb_upd_valid,
               bus.btb_upd_pc, bus.btb_upd_target, bus.btb_upd_type); end
    step();
    vecs++; if (bus.btb_upd_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errs++;
      $display("FAIL dual_empty got %b/%0d want 0/0", bus.btb_upd_valid, bus.fifo_count); end
  endtask

  task automatic test_duplicate();
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h300; bus.req0_target = 32'hA0; bus.req0_type = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_pc = 32'h302; bus.req1_target = 32'hB0; bus.req1_type = 2'b11;
    step();
    idle_inputs();
    #1;
    vecs++; if (bus.fifo_count !== 3'd1) begin errs++;
      $display("FAIL dup_count got %0d want 1", bus.fifo_count); end
    vecs++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_target !== 32'hB0 ||
                bus.btb_upd_pc !== 32'h302 || bus.btb_upd_type !== 2'b11) begin errs++;
      $display("FAIL dup_write got %b %h %h %b want 1 302 b0 11", bus.btb_upd_valid,
               bus.btb_upd_pc, bus.btb_upd_target, bus.btb_upd_type); end
    step();
    vecs++; if (bus.btb_upd_valid !== 1'b0) begin errs++;
      $display("FAIL dup_single got %b want 0", bus.btb_upd_valid); end
  endtask

  // One enqueue and one pop per cycle; six entries also wrap the pointers
  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      bus.req0_valid  = 1'b1;
      bus.req0_pc     = 32'h1000 + 32'(4 * k);
      bus.req0_target = 32'h8000 + 32'(k);
      bus.req0_type   = 2'(k);
      step();
      vecs++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_pc !== 32'h1000 + 32'(4 * k) ||
                  bus.btb_upd_target !== 32'h8000 + 32'(k) || bus.fifo_count !== 3'd1) begin
        errs++; $display("FAIL b2b_%0d got %b %h %h cnt %0d want 1 %h %h cnt 1", k,
                         bus.btb_upd_valid, bus.btb_upd_pc, bus.btb_upd_target, bus.fifo_count,
                         32'h1000 + 32'(4 * k), 32'h8000 + 32'(k)); end
    end
    idle_inputs();
    step();
    vecs++; if (bus.fifo_count !== 3'd0 || bus.btb_upd_valid !== 1'b0) begin errs++;
      $display("FAIL b2b_drain got %0d/%b want 0/0", bus.fifo_count, bus.btb_upd_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [4];
    logic        saw_upd;
    int          waited;
    exp_pc[0] = 32'h10; exp_pc[1] = 32'h20; exp_pc[2] = 32'h30; exp_pc[3] = 32'h40;
    bus.flush_req = 1'b1;
    step();
    idle_inputs();
    vecs++; if (bus.flush_busy !== 1'b1 || bus.btb_inv_valid !== 1'b1 ||
                bus.btb_inv_index !== 9'd0) begin errs++;
      $display("FAIL bp_sweep_start got %b %b %0d want 1 1 0", bus.flush_busy,
               bus.btb_inv_valid, bus.btb_inv_index); end
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h10; bus.req0_target = 32'h110;
    bus.req1_valid = 1'b1; bus.req1_pc = 32'h20; bus.req1_target = 32'h120;
    step();
    vecs++; if (bus.fifo_count !== 3'd2 || bus.req_ready !== 1'b1 ||
                bus.btb_upd_valid !== 1'b0) begin errs++;
      $display("FAIL bp_fill2 got cnt %0d rdy %b upd %b want 2 1 0", bus.fifo_count,
               bus.req_ready, bus.btb_upd_valid); end
    bus.req0_pc = 32'h30; bus.req0_target = 32'h130;
    bus.req1_pc = 32'h40; bus.req1_target = 32'h140;
    step();
    vecs++; if (bus.fifo_count !== 3'd4 || bus.req_ready !== 1'b0) begin errs++;
      $display("FAIL bp_full got cnt %0d rdy %b want 4 0", bus.fifo_count, bus.req_ready); end
    bus.req0_pc = 32'h50; bus.req1_pc = 32'h60;
    step();
    idle_inputs();
    vecs++; if (bus.fifo_count !== 3'd4) begin errs++;
      $display("FAIL bp_drop got cnt %0d want 4", bus.fifo_count); end
    saw_upd = 1'b0;
    waited  = 0;
    while (bus.flush_busy === 1'b1 && waited < 600) begin
      if (bus.btb_upd_valid !== 1'b0) saw_upd = 1'b1;
      step();
      waited++;
    end
    vecs++; if (bus.flush_busy !== 1'b0) begin errs++;
      $display("FAIL bp_sweep_end got busy %b want 0", bus.flush_busy); end
    vecs++; if (saw_upd !== 1'b0) begin errs++;
      $display("FAIL bp_held got write-during-sweep %b want 0", saw_upd); end
    for (int k = 0; k < 4; k++) begin
      vecs++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_pc !== exp_pc[k] ||
                  bus.btb_inv_valid !== 1'b0) begin errs++;
        $display("FAIL bp_write_%0d got %b %h inv %b want 1 %h inv 0", k, bus.btb_upd_valid,
                 bus.btb_upd_pc, bus.btb_inv_valid, exp_pc[k]); end
      if (k == 1) begin
        vecs++; if (bus.fifo_count !== 3'd3 || bus.req_ready !== 1'b0) begin errs++;
          $display("FAIL bp_cnt3 got cnt %0d rdy %b want 3 0", bus.fifo_count, bus.req_ready); end
        bus.req0_valid = 1'b1; bus.req0_pc = 32'h70;
        bus.req1_valid = 1'b1; bus.req1_pc = 32'h80;
      end
      step();
      idle_inputs();
    end
    vecs++; if (bus.btb_upd_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errs++;
      $display("FAIL bp_exact4 got %b cnt %0d want 0 0", bus.btb_upd_valid, bus.fifo_count); end
  endtask

  task automatic test_flush();
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h500; bus.req0_target = 32'h1500;
    bus.req1_valid = 1'b1; bus.req1_pc = 32'h600; bus.req1_target = 32'h1600;
    step();
    idle_inputs();
    bus.flush_req  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h700;
    #1;
    vecs++; if (bus.fifo_count !== 3'd2 || bus.btb_upd_valid !== 1'b0) begin errs++;
      $display("FAIL flush_pop_block got cnt %0d upd %b want 2 0", bus.fifo_count,
               bus.btb_upd_valid); end
    step();
    idle_inputs();
    vecs++; if (bus.fifo_count !== 3'd0 || bus.flush_busy !== 1'b1) begin errs++;
      $display("FAIL flush_clear got cnt %0d busy %b want 0 1", bus.fifo_count,
               bus.flush_busy); end
    for (int i = 0; i < 512; i++) begin
      vecs++; if (bus.btb_inv_valid !== 1'b1 || bus.btb_inv_index !== 9'(i) ||
                  bus.btb_upd_valid !== 1'b0 || bus.flush_busy !== 1'b1) begin errs++;
        $display("FAIL flush_idx got inv %b idx %0d upd %b busy %b want 1 %0d 0 1",
                 bus.btb_inv_valid, bus.btb_inv_index, bus.btb_upd_valid, bus.flush_busy, i); end
      step();
    end
    vecs++; if (bus.flush_busy !== 1'b0 || bus.btb_inv_valid !== 1'b0) begin errs++;
      $display("FAIL flush_done got busy %b inv %b want 0 0", bus.flush_busy,
               bus.btb_inv_valid); end
    vecs++; if (bus.btb_upd_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errs++;
      $display("FAIL flush_stale got upd %b cnt %0d want 0 0", bus.btb_upd_valid,
               bus.fifo_count); end
  endtask

  task automatic test_reset_mid_sweep();
    bus.flush_req = 1'b1;
    step();
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h900;
    step();
    idle_inputs();
    vecs++; if (bus.fifo_count !== 3'd1) begin errs++;
      $display("FAIL rms_enq got cnt %0d want 1", bus.fifo_count); end
    for (int i = 1; i < 100; i++) step();
    vecs++; if (bus.btb_inv_index !== 9'd100) begin errs++;
      $display("FAIL rms_index got %0d want 100", bus.btb_inv_index); end
    rst = 1'b1;
    step();
    vecs++; if (bus.flush_busy !== 1'b0 || bus.btb_inv_valid !== 1'b0) begin errs++;
      $display("FAIL rms_abort got busy %b inv %b want 0 0", bus.flush_busy,
               bus.btb_inv_valid); end
    vecs++; if (bus.fifo_count !== 3'd0 || bus.req_ready !== 1'b1) begin errs++;
      $display("FAIL rms_fifo got cnt %0d rdy %b want 0 1", bus.fifo_count, bus.req_ready); end
    rst = 1'b0;
    step();
    vecs++; if (bus.btb_upd_valid !== 1'b0 || bus.flush_busy !== 1'b0) begin errs++;
      $display("FAIL rms_after got upd %b busy %b want 0 0", bus.btb_upd_valid,
               bus.flush_busy); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_dual();
    test_duplicate();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
